prog_ctr_fetch: RTL and testbench

- Program counter and fetch-sequencing stage directly downstream of the branch-target LUT.
- Consumes the LUT's absolute D-bit `Target` and the decoded branch/halt controls, and holds the registered PC that addresses instruction memory.
- Runs a Start/Done handshake with the testbench or top level, with stall support and a saturating run-cycle counter.

---
 rtl/prog_ctr_pkg.sv | 20 ++
 rtl/prog_ctr_fetch_sat_counter.sv | 29 ++
 rtl/prog_ctr_fetch.sv | 93 +++++++++
 tb/tb_prog_ctr_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// Shared types and constants for the program-counter / fetch-sequencing stage.
//   PC_W    : program counter width (matches branch-target LUT width)
//   CYC_W   : run-cycle counter width
//   pc_t    : program counter type
//   state_e : fetch sequencer states
package prog_ctr_pkg;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CYC_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/prog_ctr_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_en    : count enable
//   i_clr   : synchronous clear (wins over i_en)
//   o_count : current count; sticks at all-ones, never wraps
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch sequencer, downstream of the branch-target LUT.
// Launches on the falling edge of Start (IDLE -> ARMED -> RUN), advances PC
// each RUN cycle with priority Halt > Stall > Branch > increment, and parks
// in HALTED until Start re-arms it.
//   Clk     : clock
//   Reset   : synchronous active-low reset
//   Start   : level launch handshake
//   Branch  : branch taken this cycle
//   Target  : absolute branch target (used only when Branch=1)
//   Stall   : hold PC this cycle
//   Halt    : halt instruction at current PC
//   PC      : registered program counter
//   Running : state is RUN
//   Done    : state is HALTED
//   Cycles  : saturating count of RUN cycles since launch
module prog_ctr_fetch
  import prog_ctr_pkg::*;
#(
  parameter int unsigned D = PC_W,
  parameter int unsigned C = CYC_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Branch,
  input  logic [D-1:0] Target,
  input  logic         Stall,
  input  logic         Halt,
  output logic [D-1:0] PC,
  output logic         Running,
  output logic         Done,
  output logic [C-1:0] Cycles
);

  state_e       r_state;
  logic [D-1:0] r_pc;
  logic         w_run;
  logic         w_rearm;

  assign w_run   = (r_state == ST_RUN);
  assign w_rearm = (r_state == ST_HALTED) && Start;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc <= '0;
          if (Start) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!Start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (Halt) begin
            r_state <= ST_HALTED;
          end else if (!Stall) begin
            // A stalled branch is dropped; upstream re-presents it.
            r_pc <= Branch ? Target : r_pc + D'(1);
          end
        end
        ST_HALTED: begin
          if (Start) begin
            r_state <= ST_ARMED;
            r_pc    <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pc    <= '0;
        end
      endcase
    end
  end

  // Counts every RUN edge, including stalls and the halting edge.
  sat_counter #(
    .W (C)
  ) u_cycles (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_en    (w_run),
    .i_clr   (w_rearm),
    .o_count (Cycles)
  );

  assign PC      = r_pc;
  assign Running = w_run;
  assign Done    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_prog_ctr_fetch.sv
module tb_prog_ctr_fetch;
  import prog_ctr_pkg::*;

  localparam int unsigned D  = PC_W;
  localparam int unsigned C  = CYC_W;
  localparam int unsigned C4 = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_HALT  = 3;

  logic          Clk    = 1'b0;
  logic          Reset  = 1'b0;
  logic          Start  = 1'b0;
  logic          Branch = 1'b0;
  logic          Stall  = 1'b0;
  logic          Halt   = 1'b0;
  pc_t           Target = '0;
  pc_t           PC, PC4;
  logic          Running, Done, Running4, Done4;
  logic [C-1:0]  Cycles;
  logic [C4-1:0] Cycles4;

  prog_ctr_fetch #(.D(D), .C(C)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Target(Target),
    .Stall(Stall), .Halt(Halt), .PC(PC), .Running(Running), .Done(Done), .Cycles(Cycles)
  );

  prog_ctr_fetch #(.D(D), .C(C4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Target(Target),
    .Stall(Stall), .Halt(Halt), .PC(PC4), .Running(Running4), .Done(Done4), .Cycles(Cycles4)
  );

  always #5 Clk = ~Clk;

  typedef logic [2*D+4+C+C4-1:0] obs_t;

  obs_t        sb[$];
  obs_t        e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_st     = M_IDLE;
  pc_t         m_pc     = '0;
  int unsigned m_cyc    = 0;
  int unsigned m_cyc4   = 0;

  function automatic obs_t observe();
    return {PC, Running, Done, Cycles, PC4, Running4, Done4, Cycles4};
  endfunction

  // Drive one cycle of inputs, advance the reference model, queue the
  // expected post-edge outputs, then move to the sample point.
  task automatic step(input logic rst, input logic st, input logic br,
                      input logic stl, input logic hlt, input pc_t tgt);
    Reset = rst; Start = st; Branch = br; Stall = stl; Halt = hlt; Target = tgt;
    if (!rst) begin
      m_st = M_IDLE; m_pc = '0; m_cyc = 0; m_cyc4 = 0;
    end else begin
      case (m_st)
        M_IDLE:  begin m_pc = '0; if (st) m_st = M_ARMED; end
        M_ARMED: if (!st) m_st = M_RUN;
        M_RUN: begin
          if (m_cyc < 65535) m_cyc++;
          if (m_cyc4 < 15) m_cyc4++;
          if (hlt) m_st = M_HALT;
          else if (stl) m_pc = m_pc;
          else if (br) m_pc = tgt;
          else m_pc = m_pc + 1'b1;
        end
        default: if (st) begin m_st = M_ARMED; m_pc = '0; m_cyc = 0; m_cyc4 = 0; end
      endcase
    end
    sb.push_back({m_pc, m_st == M_RUN, m_st == M_HALT, C'(m_cyc),
                  m_pc, m_st == M_RUN, m_st == M_HALT, C4'(m_cyc4)});
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd77);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e) $display("FAIL reset_model: actual=%h required=%h", observe(), e);
      else n_pass++;
      n_checks++;
      if ({PC, Running, Done, Cycles} !== '0)
        $display("FAIL reset_zero: actual=%h required=0", {PC, Running, Done, Cycles});
      else n_pass++;
    end
  endtask

  task automatic test_launch();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e || Running !== 1'b0 || PC !== '0 || Done !== 1'b0)
        $display("FAIL launch_armed: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || Running !== 1'b1 || PC !== '0)
      $display("FAIL launch_run: actual=%h required=%h", observe(), e);
    else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e || PC !== pc_t'(i))
        $display("FAIL launch_inc: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 1100 && m_pc != 10'd5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e) $display("FAIL branch_seek: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd47);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd47)
      $display("FAIL branch_take: actual=%h required=%h", observe(), e);
    else n_pass++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd48)
      $display("FAIL branch_after: actual=%h required=%h", observe(), e);
    else n_pass++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd281);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd49)
      $display("FAIL branch_ignored: actual=%h required=%h", observe(), e);
    else n_pass++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd0 || Running !== 1'b1)
      $display("FAIL branch_zero: actual=%h required=%h", observe(), e);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [C-1:0] cyc0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd12);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd12)
      $display("FAIL stall_setup: actual=%h required=%h", observe(), e);
    else n_pass++;
    cyc0 = Cycles;
    for (int i = 1; i <= 2; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd189);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e || PC !== 10'd12 || Cycles !== cyc0 + C'(i))
        $display("FAIL stall_hold: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd189);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd189 || Cycles !== cyc0 + C'(3))
      $display("FAIL stall_release: actual=%h required=%h", observe(), e);
    else n_pass++;
  endtask

  task automatic test_halt();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front(); n_checks++;
      if (i == 2 && observe() !== e) $display("FAIL halt_launch: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
    for (int i = 0; i < 99; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e) $display("FAIL halt_run: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, (i == 0), 10'd5);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e || PC !== 10'd99 || Done !== 1'b1 || Running !== 1'b0 ||
          Cycles !== 16'd100 || Cycles4 !== 4'd15)
        $display("FAIL halt_frozen: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== '0 || Cycles !== '0 || Done !== 1'b0 || Running !== 1'b0)
      $display("FAIL halt_rearm: actual=%h required=%h", observe(), e);
    else n_pass++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || Running !== 1'b1 || PC !== '0)
      $display("FAIL halt_relaunch: actual=%h required=%h", observe(), e);
    else n_pass++;
  endtask

  task automatic test_wrap();
    pc_t exp_pc;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1020);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd1020)
      $display("FAIL wrap_setup: actual=%h required=%h", observe(), e);
    else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd700);
      exp_pc = pc_t'(1020 + i);
      e = sb.pop_front(); n_checks++;
      if (observe() !== e || PC !== exp_pc || PC4 !== exp_pc)
        $display("FAIL wrap_pc: actual=%h required=%h", observe(), e);
      else n_pass++;
    end
    n_checks++;
    if (Cycles4 !== 4'd15) $display("FAIL sat_cycles: actual=%0d required=15", Cycles4);
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd323);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== 10'd323)
      $display("FAIL midreset_setup: actual=%h required=%h", observe(), e);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd500);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== '0 || Running !== 1'b0 || Done !== 1'b0 || Cycles !== '0)
      $display("FAIL midreset: actual=%h required=%h", observe(), e);
    else n_pass++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd500);
    e = sb.pop_front(); n_checks++;
    if (observe() !== e || PC !== '0 || Running !== 1'b0)
      $display("FAIL midreset_idle: actual=%h required=%h", observe(), e);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_branch();
    test_stall();
    test_halt();
    test_wrap();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
